// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// It captures the ID-stage control bundle, the register read data, the immediate and the
// register specifiers, and presents them to EX, forwarding and hazard logic.
// Priority at each edge: flush > stall > load.
// A load with Valid_i=0 clears the control fields but still loads the data and specifier fields.
// Optional build macro ID_EX_BUBBLE_CNT_EN adds a saturating bubble counter (BubbleCnt_o).
module id_ex_pipe_reg #(
    parameter int DATA_W = 32
`ifdef ID_EX_BUBBLE_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              Valid_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              RegDst_i,
    input  logic              MemRd_i,
    input  logic              MemWr_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic [DATA_W-1:0] RD1_i,
    input  logic [DATA_W-1:0] RD2_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [4:0]        RS_i,
    input  logic [4:0]        RT_i,
    input  logic [4:0]        RD_i,
    output logic              Valid_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic              RegDst_o,
    output logic              MemRd_o,
    output logic              MemWr_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] RD1_o,
    output logic [DATA_W-1:0] RD2_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [4:0]        RS_o,
    output logic [4:0]        RT_o,
    output logic [4:0]        RD_o
`ifdef ID_EX_BUBBLE_CNT_EN
    , output logic [CNT_W-1:0] BubbleCnt_o
`endif
);

    logic              valid_q, valid_d;
    logic              alu_src_q, alu_src_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              reg_dst_q, reg_dst_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;

    // Next-state selection: hold by default, flush clears everything, load copies inputs
    always_comb begin
        valid_d      = valid_q;
        alu_src_d    = alu_src_q;
        alu_op_d     = alu_op_q;
        reg_dst_d    = reg_dst_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        if (flush_i) begin
            // Specifiers are cleared too so a bubble never matches in forwarding logic
            valid_d      = 1'b0;
            alu_src_d    = 1'b0;
            alu_op_d     = 2'b00;
            reg_dst_d    = 1'b0;
            mem_rd_d     = 1'b0;
            mem_wr_d     = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
        end else if (!stall_i) begin
            valid_d = Valid_i;
            rd1_d   = RD1_i;
            rd2_d   = RD2_i;
            imm_d   = Imm_i;
            rs_d    = RS_i;
            rt_d    = RT_i;
            rd_d    = RD_i;
            // Control fields are loaded only for a real instruction
            if (Valid_i) begin
                alu_src_d    = ALUSrc_i;
                alu_op_d     = ALUOp_i;
                reg_dst_d    = RegDst_i;
                mem_rd_d     = MemRd_i;
                mem_wr_d     = MemWr_i;
                mem_to_reg_d = MemtoReg_i;
                reg_write_d  = RegWrite_i;
            end else begin
                alu_src_d    = 1'b0;
                alu_op_d     = 2'b00;
                reg_dst_d    = 1'b0;
                mem_rd_d     = 1'b0;
                mem_wr_d     = 1'b0;
                mem_to_reg_d = 1'b0;
                reg_write_d  = 1'b0;
            end
        end
    end

    // Pipeline register state with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            reg_dst_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            reg_dst_q    <= reg_dst_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
        end
    end

    assign Valid_o    = valid_q;
    assign ALUSrc_o   = alu_src_q;
    assign ALUOp_o    = alu_op_q;
    assign RegDst_o   = reg_dst_q;
    assign MemRd_o    = mem_rd_q;
    assign MemWr_o    = mem_wr_q;
    assign MemtoReg_o = mem_to_reg_q;
    assign RegWrite_o = reg_write_q;
    assign RD1_o      = rd1_q;
    assign RD2_o      = rd2_q;
    assign Imm_o      = imm_q;
    assign RS_o       = rs_q;
    assign RT_o       = rt_q;
    assign RD_o       = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Count flush edges, saturating at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush_i && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed pipeline scenarios plus random stall/flush traffic.
module tb_id_ex_pipe_reg;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic        valid;
        logic        alusrc;
        logic [1:0]  aluop;
        logic        regdst;
        logic        memrd;
        logic        memwr;
        logic        memtoreg;
        logic        regwrite;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct packed {
        bundle_t     s;
        int unsigned cnt;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    stall = 1'b0;
    logic    flush = 1'b0;
    bundle_t in_s = '0;
    bundle_t out_s;

    logic        o_valid, o_alusrc, o_regdst, o_memrd, o_memwr, o_memtoreg, o_regwrite;
    logic [1:0]  o_aluop;
    logic [31:0] o_rd1, o_rd2, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] o_cnt;
`endif

    // Reference state of the EX stage and bubble count
    bundle_t     model = '0;
    int unsigned model_cnt = 0;
    exp_t        sb_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W(32)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .Valid_i(in_s.valid), .ALUSrc_i(in_s.alusrc), .ALUOp_i(in_s.aluop),
        .RegDst_i(in_s.regdst), .MemRd_i(in_s.memrd), .MemWr_i(in_s.memwr),
        .MemtoReg_i(in_s.memtoreg), .RegWrite_i(in_s.regwrite),
        .RD1_i(in_s.rd1), .RD2_i(in_s.rd2), .Imm_i(in_s.imm),
        .RS_i(in_s.rs), .RT_i(in_s.rt), .RD_i(in_s.rd),
        .Valid_o(o_valid), .ALUSrc_o(o_alusrc), .ALUOp_o(o_aluop),
        .RegDst_o(o_regdst), .MemRd_o(o_memrd), .MemWr_o(o_memwr),
        .MemtoReg_o(o_memtoreg), .RegWrite_o(o_regwrite),
        .RD1_o(o_rd1), .RD2_o(o_rd2), .Imm_o(o_imm),
        .RS_o(o_rs), .RT_o(o_rt), .RD_o(o_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .BubbleCnt_o(o_cnt)
`endif
    );

    assign out_s = {o_valid, o_alusrc, o_aluop, o_regdst, o_memrd, o_memwr, o_memtoreg,
                    o_regwrite, o_rd1, o_rd2, o_imm, o_rs, o_rt, o_rd};

    // Pipeline rules: flush yields an empty slot, stall keeps the old one,
    // otherwise the instruction advances and a non-valid one carries no control.
    function automatic bundle_t next_state(bundle_t cur, bundle_t din, logic st, logic fl);
        bundle_t n;
        if (fl) return '0;
        if (st) return cur;
        n = din;
        if (!din.valid) begin
            n.alusrc = 0; n.aluop = 0; n.regdst = 0; n.memrd = 0;
            n.memwr = 0; n.memtoreg = 0; n.regwrite = 0;
        end
        return n;
    endfunction

    function automatic bundle_t rand_bundle();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[119:0];
    endfunction

    // One clock edge: advance the model and queue what EX should hold afterwards
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model = next_state(model, in_s, stall, flush);
            if (flush && model_cnt < (2**CNT_W) - 1) model_cnt++;
        end
        sb_q.push_back('{s: model, cnt: model_cnt});
        #1;
    endtask

    // Raise reset mid-cycle with busy inputs; the clear must be visible before the next edge
    task automatic apply_reset(input logic st_at_release, input logic fl_at_release);
        @(posedge clk);
        #1;
        in_s = rand_bundle();
        in_s.valid = 1'b1;
        in_s.regwrite = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        model = '0;
        model_cnt = 0;
        sb_q.push_back('{s: model, cnt: model_cnt});
        tick();
        stall = st_at_release;
        flush = fl_at_release;
        rst = 1'b0;
    endtask

    // Monitor: compare the presented EX bundle against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (out_s !== e.s) begin
                errors++;
                $display("FAIL ex_bundle t=%0t got=%h exp=%h", $time, out_s, e.s);
            end
`ifdef ID_EX_BUBBLE_CNT_EN
            checks++;
            if (int'(o_cnt) != e.cnt) begin
                errors++;
                $display("FAIL bubble_cnt t=%0t got=%0d exp=%0d", $time, o_cnt, e.cnt);
            end
`endif
            checks++;
            if (!o_valid && (o_regwrite || o_memrd || o_memwr || o_aluop != 2'b00)) begin
                errors++;
                $display("FAIL bubble_invariant t=%0t got=%h exp=no control when invalid",
                         $time, out_s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bundle_t lw, rtype, sw;

        apply_reset(1'b0, 1'b0);

        // lw advances in one edge
        lw = '0;
        lw.valid = 1; lw.alusrc = 1; lw.memrd = 1; lw.memtoreg = 1; lw.regwrite = 1;
        lw.rd1 = 32'h10; lw.imm = 32'h4; lw.rt = 5'd8;
        in_s = lw;
        tick();

        // R-type loaded, then held across three stalled edges while sw waits in ID
        rtype = rand_bundle();
        rtype.valid = 1; rtype.aluop = 2'b10; rtype.regdst = 1; rtype.regwrite = 1;
        rtype.alusrc = 0; rtype.memrd = 0; rtype.memwr = 0; rtype.memtoreg = 0;
        in_s = rtype;
        tick();
        sw = rand_bundle();
        sw.valid = 1; sw.alusrc = 1; sw.memwr = 1; sw.memrd = 0; sw.regwrite = 0;
        sw.aluop = 2'b00; sw.memtoreg = 0;
        in_s = sw;
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        tick();

        // flush wins over stall
        in_s = rtype;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;

        // invalid instruction: control dropped, specifiers kept
        in_s = rand_bundle();
        in_s.valid = 0; in_s.aluop = 2'b10; in_s.regwrite = 1; in_s.rs = 5'd3;
        tick();

        // saturation of the bubble count from a clean reset
        apply_reset(1'b0, 1'b1);
        repeat (5) begin
            in_s = rand_bundle();
            tick();
        end
        flush = 1'b0;

        // reset released while stall is requested: first edge holds the cleared state
        apply_reset(1'b1, 1'b0);
        in_s = rand_bundle();
        in_s.valid = 1'b1;
        tick();
        stall = 1'b0;
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_s = rand_bundle();
            in_s.valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            tick();
        end
        stall = 1'b0;
        flush = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
